// File: rtl/oldland_memstage.sv
// Memory-access stage of the oldland pipeline: drives the data-bus handshake
// for loads and stores, aligns load data, passes ALU results through to
// writeback, stalls while a transfer is outstanding and signals aborts for
// misalignment, bus errors and transfer timeouts.
module oldland_memstage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [3:0]  rd_sel,
  input  logic        i_valid,
  output logic [29:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic        d_wr_en,
  output logic        d_access,
  output logic [31:0] d_data_out,
  input  logic [31:0] d_data_in,
  input  logic        d_ack,
  input  logic        d_error,
  output logic        busy,
  output logic        data_abort,
  output logic [31:0] wb_val,
  output logic        wb_en,
  output logic [3:0]  wb_rd_sel,
  output logic        i_valid_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // The counter starts at zero on WAIT entry, so the last permitted WAIT
  // cycle is the one in which it holds TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  logic [7:0] wait_cnt;

  logic       load_p1;
  logic [1:0] width_p1;
  logic [1:0] lane_p1;
  logic [3:0] rd_sel_p1;
  logic       wr_result_p1;

  logic mem_req;
  logic misaligned;
  logic accept;
  logic bus_done;
  logic timeout;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      2'b00:   lane_enables = 4'b0001 << lane;
      2'b01:   lane_enables = 4'b0011 << lane;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] data);
    case (width)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] width, input logic [1:0] lane,
                                             input logic [31:0] data);
    logic [31:0] shifted;
    shifted = data >> {lane, 3'b000};
    case (width)
      2'b00:   load_align = {24'd0, shifted[7:0]};
      2'b01:   load_align = {16'd0, shifted[15:0]};
      default: load_align = data;
    endcase
  endfunction

  assign mem_req    = (mem_load | mem_store) & i_valid;
  assign misaligned = is_misaligned(mem_width, mar[1:0]);
  assign accept     = (state == IDLE) && mem_req && !misaligned;
  assign bus_done   = (state == WAIT) && (d_ack || d_error);
  assign timeout    = (state == WAIT) && !(d_ack || d_error) && (wait_cnt == TO_LAST);

  // Stall upstream while a transfer is being accepted or is still in flight.
  assign busy = accept || ((state == WAIT) && !bus_done && !timeout);

  // Request attributes needed to complete the instruction once the bus answers.
  always_ff @(posedge clk) begin
    if (accept) begin
      load_p1      <= !mem_store;
      width_p1     <= mem_width;
      lane_p1      <= mar[1:0];
      rd_sel_p1    <= rd_sel;
      wr_result_p1 <= wr_result;
    end
  end

  // State machine, bus request outputs and writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      d_addr      <= 30'd0;
      d_bytesel   <= 4'd0;
      d_wr_en     <= 1'b0;
      d_access    <= 1'b0;
      d_data_out  <= 32'd0;
      data_abort  <= 1'b0;
      wb_val      <= 32'd0;
      wb_en       <= 1'b0;
      wb_rd_sel   <= 4'd0;
      i_valid_out <= 1'b0;
    end else begin
      wb_en       <= 1'b0;
      i_valid_out <= 1'b0;
      data_abort  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (misaligned) begin
              data_abort  <= 1'b1;
              i_valid_out <= 1'b1;
              wb_rd_sel   <= rd_sel;
            end else begin
              state      <= WAIT;
              wait_cnt   <= 8'd0;
              d_access   <= 1'b1;
              d_addr     <= mar[31:2];
              d_bytesel  <= lane_enables(mem_width, mar[1:0]);
              d_wr_en    <= mem_store;
              d_data_out <= store_lanes(mem_width, mdr);
            end
          end else begin
            wb_val      <= wr_val;
            wb_en       <= wr_result & i_valid;
            wb_rd_sel   <= rd_sel;
            i_valid_out <= i_valid;
          end
        end
        WAIT: begin
          if (bus_done || timeout) begin
            state       <= IDLE;
            d_access    <= 1'b0;
            d_addr      <= 30'd0;
            d_bytesel   <= 4'd0;
            d_wr_en     <= 1'b0;
            d_data_out  <= 32'd0;
            i_valid_out <= 1'b1;
            wb_rd_sel   <= rd_sel_p1;
            if (d_error || timeout) begin
              data_abort <= 1'b1;
            end else if (load_p1) begin
              wb_val <= load_align(width_p1, lane_p1, d_data_in);
              wb_en  <= wr_result_p1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_memstage.sv
// Directed bench for oldland_memstage: loads, stores, aborts, timeout,
// passthrough and reset during an outstanding transfer.
module tb_oldland_memstage;

  logic        clk;
  logic        rst;
  logic        mem_load;
  logic        mem_store;
  logic [1:0]  mem_width;
  logic [31:0] mar;
  logic [31:0] mdr;
  logic [31:0] wr_val;
  logic        wr_result;
  logic [3:0]  rd_sel;
  logic        i_valid;
  logic [29:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic        d_access;
  logic [31:0] d_data_out;
  logic [31:0] d_data_in;
  logic        d_ack;
  logic        d_error;
  logic        busy;
  logic        data_abort;
  logic [31:0] wb_val;
  logic        wb_en;
  logic [3:0]  wb_rd_sel;
  logic        i_valid_out;

  int n_vec;
  int n_err;
  int busy_cycles;
  int access_cycles;

  oldland_memstage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_load(mem_load), .mem_store(mem_store), .mem_width(mem_width),
    .mar(mar), .mdr(mdr), .wr_val(wr_val), .wr_result(wr_result),
    .rd_sel(rd_sel), .i_valid(i_valid),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
    .d_access(d_access), .d_data_out(d_data_out), .d_data_in(d_data_in),
    .d_ack(d_ack), .d_error(d_error), .busy(busy), .data_abort(data_abort),
    .wb_val(wb_val), .wb_en(wb_en), .wb_rd_sel(wb_rd_sel),
    .i_valid_out(i_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_width = 2'b00;
    mar       = 32'd0;
    mdr       = 32'd0;
    wr_val    = 32'd0;
    wr_result = 1'b0;
    rd_sel    = 4'd0;
    i_valid   = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] rd);
    mem_load  = ld;
    mem_store = st;
    mem_width = w;
    mar       = a;
    mdr       = d;
    wr_result = ld;
    rd_sel    = rd;
    i_valid   = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    d_data_in = 32'd0;
    d_ack     = 1'b0;
    d_error   = 1'b0;
    rst       = 1'b1;
    #22 rst = 1'b0;
    #1;
    chk("reset_access", {31'd0, d_access}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset_wb_val", wb_val, 32'd0);
    chk("reset_abort", {31'd0, data_abort}, 32'd0);
    chk("reset_ivout", {31'd0, i_valid_out}, 32'd0);
    chk("reset_addr", {2'd0, d_addr}, 32'd0);

    // Word load at 0x100, ack in the third WAIT cycle
    tick();
    issue(1'b1, 1'b0, 2'b10, 32'h100, 32'd0, 4'd5);
    busy_cycles = 0;
    #1 busy_cycles += int'(busy);
    tick();
    idle_inputs();
    chk("wl_access", {31'd0, d_access}, 32'd1);
    chk("wl_addr", {2'd0, d_addr}, 32'h40);
    chk("wl_bytesel", {28'd0, d_bytesel}, 32'hF);
    chk("wl_wr_en", {31'd0, d_wr_en}, 32'd0);
    busy_cycles += int'(busy);
    tick();
    busy_cycles += int'(busy);
    tick();
    d_ack = 1'b1;
    d_data_in = 32'hDEADBEEF;
    #1 busy_cycles += int'(busy);
    chk("wl_busy_cycles", busy_cycles, 32'd3);
    tick();
    d_ack = 1'b0;
    chk("wl_wb_val", wb_val, 32'hDEADBEEF);
    chk("wl_wb_en", {31'd0, wb_en}, 32'd1);
    chk("wl_wb_rd", {28'd0, wb_rd_sel}, 32'd5);
    chk("wl_ivout", {31'd0, i_valid_out}, 32'd1);
    chk("wl_access_drop", {31'd0, d_access}, 32'd0);
    tick();
    chk("wl_wb_en_pulse", {31'd0, wb_en}, 32'd0);

    // Byte load at 0x103
    issue(1'b1, 1'b0, 2'b00, 32'h103, 32'd0, 4'd6);
    tick();
    idle_inputs();
    chk("bl_bytesel", {28'd0, d_bytesel}, 32'h8);
    d_ack = 1'b1;
    d_data_in = 32'hAABBCCDD;
    tick();
    d_ack = 1'b0;
    chk("bl_wb_val", wb_val, 32'h000000AA);
    chk("bl_wb_en", {31'd0, wb_en}, 32'd1);
    tick();

    // Half store at 0x202
    issue(1'b0, 1'b1, 2'b01, 32'h202, 32'h1234, 4'd7);
    tick();
    idle_inputs();
    chk("hs_bytesel", {28'd0, d_bytesel}, 32'hC);
    chk("hs_wr_en", {31'd0, d_wr_en}, 32'd1);
    chk("hs_data_out", d_data_out, 32'h12341234);
    chk("hs_addr", {2'd0, d_addr}, 32'h80);
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    chk("hs_wb_en", {31'd0, wb_en}, 32'd0);
    chk("hs_ivout", {31'd0, i_valid_out}, 32'd1);
    chk("hs_wr_en_drop", {31'd0, d_wr_en}, 32'd0);
    tick();

    // Misaligned word load at 0x101
    issue(1'b1, 1'b0, 2'b10, 32'h101, 32'd0, 4'd2);
    #1 chk("mis_busy", {31'd0, busy}, 32'd0);
    tick();
    idle_inputs();
    chk("mis_access", {31'd0, d_access}, 32'd0);
    chk("mis_abort", {31'd0, data_abort}, 32'd1);
    chk("mis_wb_en", {31'd0, wb_en}, 32'd0);
    chk("mis_ivout", {31'd0, i_valid_out}, 32'd1);
    tick();
    chk("mis_abort_pulse", {31'd0, data_abort}, 32'd0);

    // Error and ack together: error wins
    issue(1'b1, 1'b0, 2'b10, 32'h104, 32'd0, 4'd3);
    tick();
    idle_inputs();
    d_ack = 1'b1;
    d_error = 1'b1;
    d_data_in = 32'h11111111;
    #1 chk("err_busy", {31'd0, busy}, 32'd0);
    tick();
    d_ack = 1'b0;
    d_error = 1'b0;
    chk("err_abort", {31'd0, data_abort}, 32'd1);
    chk("err_wb_en", {31'd0, wb_en}, 32'd0);
    chk("err_access", {31'd0, d_access}, 32'd0);
    tick();

    // Timeout with TIMEOUT_CYCLES=4, then a late ack
    issue(1'b1, 1'b0, 2'b10, 32'h108, 32'd0, 4'd4);
    tick();
    idle_inputs();
    access_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      access_cycles += int'(d_access);
      if (i < 3) chk("to_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("to_abort", {31'd0, data_abort}, 32'd1);
    chk("to_wb_en", {31'd0, wb_en}, 32'd0);
    access_cycles += int'(d_access);
    chk("to_access_cycles", access_cycles, 32'd4);
    d_ack = 1'b1;
    d_data_in = 32'h22222222;
    tick();
    d_ack = 1'b0;
    chk("to_late_wb_en", {31'd0, wb_en}, 32'd0);
    chk("to_late_abort", {31'd0, data_abort}, 32'd0);
    chk("to_late_access", {31'd0, d_access}, 32'd0);

    // ALU passthrough followed by a load interrupted by reset
    mem_load  = 1'b0;
    mem_store = 1'b0;
    wr_val    = 32'h55;
    wr_result = 1'b1;
    rd_sel    = 4'd3;
    i_valid   = 1'b1;
    #1 chk("alu_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("alu_wb_val", wb_val, 32'h55);
    chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
    chk("alu_wb_rd", {28'd0, wb_rd_sel}, 32'd3);
    chk("alu_ivout", {31'd0, i_valid_out}, 32'd1);
    issue(1'b1, 1'b0, 2'b10, 32'h100, 32'd0, 4'd9);
    #1 chk("rl_busy", {31'd0, busy}, 32'd1);
    tick();
    idle_inputs();
    chk("rl_access", {31'd0, d_access}, 32'd1);
    chk("rl_wb_en_pulse", {31'd0, wb_en}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("rl_access_async", {31'd0, d_access}, 32'd0);
    d_ack = 1'b1;
    d_data_in = 32'h33333333;
    tick();
    rst = 1'b0;
    tick();
    d_ack = 1'b0;
    chk("rl_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rl_ivout", {31'd0, i_valid_out}, 32'd0);
    chk("rl_access_after", {31'd0, d_access}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
